reg_file_wb: RTL and testbench
==============================

REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
Parameters:
REQ-001 DATA_W, default 32, width of each register and of the data ports.
REQ-002 NUM_REGS, default 32, number of architectural registers; address width is 5 bits.

Ports:
REQ-003 Clk  in  1  rising-edge clock for all state.
REQ-004 Rst  in  1  reset; synchronous, active-low.
REQ-005 RegWrite  in  1  write-back enable from the WB stage.
REQ-006 WriteRegister  in  5  write-back destination register.
REQ-007 WriteData  in  DATA_W  write-back value (output of the WB select mux).
REQ-008 ReadRegister1  in  5  ID read address, port 1.
REQ-009 ReadRegister2  in  5  ID read address, port 2.
REQ-010 ReadData1  out  DATA_W  read data, port 1.
REQ-011 ReadData2  out  DATA_W  read data, port 2.
REQ-012 IssueValid  in  1  an instruction with a destination register leaves ID this cycle.
REQ-013 IssueRegister  in  5  destination register of the issuing instruction.
REQ-014 Busy1  out  1  port-1 register has an older write still in flight.
REQ-015 Busy2  out  1  port-2 register has an older write still in flight.
REQ-016 Overflow  out  1  sticky flag; a pending counter saturated.

Function
REQ-017 Register storage SHALL update on the rising edge of Clk when RegWrite=1 and WriteRegister!=0.
REQ-018 Register 0 SHALL always read as 0; writes to it SHALL be ignored.
REQ-019 Read ports SHALL be combinational.
REQ-020 Same-cycle bypass: if RegWrite=1, WriteRegister!=0 and WriteRegister equals a read address, that port SHALL return WriteData.
REQ-021 Each register 1..31 SHALL have a 2-bit pending counter.
REQ-022 Pending counter SHALL increment on IssueValid=1 with IssueRegister!=0.
REQ-023 Pending counter SHALL decrement on RegWrite=1 with WriteRegister!=0.
REQ-024 If the increment and decrement hit the same register in the same cycle, its count SHALL be unchanged.
REQ-025 An increment at count 3 SHALL hold the count at 3 and set Overflow.
REQ-026 Overflow SHALL stay set until reset.
REQ-027 A decrement at count 0 SHALL hold the count at 0; the data write still commits.
REQ-028 BusyN SHALL be 1 when the count for ReadRegisterN is nonzero.
REQ-029 Exception to REQ-028: BusyN SHALL be 0 when that count is 1 and the same register is being written back this cycle (bypass covers it).
REQ-030 Busy1 and Busy2 SHALL be 0 for register 0.
REQ-031 Latency: a write is visible through the bypass in the same cycle and from storage from the next cycle.

Reset
REQ-032 While Rst=0 at a rising edge, all registers, all pending counters and Overflow SHALL clear to 0.
REQ-033 Reset SHALL take priority over simultaneous write or issue.
REQ-034 During and after reset, ReadData, Busy and Overflow outputs SHALL reflect the cleared state, apart from the combinational bypass.

Structure
REQ-035 DATA_W, the register-address width and the counter width (2) SHALL live in a shared CPU package.
REQ-036 One sub-module, pend_counter (a single 2-bit saturating up/down counter), SHALL be instantiated once per register 1..31.

Verification
REQ-037 Reset, then write 0xDEADBEEF to r5 -> next cycle ReadData1 for r5 = 0xDEADBEEF.
REQ-038 Write 0x12345678 to r0 -> ReadData1 for r0 = 0 on the same and the next cycle.
REQ-039 Read r7 while writing 0xA5A5A5A5 to r7 in the same cycle -> ReadData2 = 0xA5A5A5A5 in that cycle.
REQ-040 Issue r3 twice, write r3 once, then read r3 -> Busy1=1; on the second r3 write, Busy1=0 in that cycle; the count returns to 0.
REQ-041 Issue r9 four times with no write-back -> Overflow=1 from the fourth issue onward and the count stays at 3; a later Rst=0 clears Overflow.
REQ-042 Issue r4 and write r4 in the same cycle while the count is 1 -> the count stays at 1 and Busy for r4 stays 1 afterwards.

Source files
------------

// File: rtl/reg_file_wb_pkg.sv
// Shared CPU definitions for the register file: data/address widths, the
// pending-write counter type and its per-cycle operation encoding.
package reg_file_wb_pkg;

  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned PEND_W     = 2;
  localparam int unsigned ARCH_REGS  = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [PEND_W-1:0]     pend_cnt_t;

  localparam pend_cnt_t PEND_MAX = '1;

  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_INC,
    PEND_DEC
  } pend_op_e;

  // An issue and a write-back landing on the same register cancel out.
  function automatic pend_op_e pend_op(input logic inc, input logic dec);
    if (inc && !dec) return PEND_INC;
    if (dec && !inc) return PEND_DEC;
    return PEND_HOLD;
  endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
// sat flags an increment attempted while already at the maximum.
module pend_counter
  import reg_file_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      inc,
  input  logic      dec,
  output pend_cnt_t count,
  output logic      sat
);

  pend_op_e  op;
  pend_cnt_t count_q;
  pend_cnt_t count_d;

  always_comb begin
    op      = pend_op(inc, dec);
    count_d = count_q;
    sat     = 1'b0;
    case (op)
      PEND_INC: begin
        if (count_q == PEND_MAX) sat = 1'b1;
        else count_d = count_q + 1'b1;
      end
      PEND_DEC: begin
        if (count_q != '0) count_d = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/reg_file_wb.sv
// Two-read/one-write register file with write-back bypass and per-register
// pending-write scoreboard producing busy flags and a sticky overflow.
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = CPU_DATA_W,
  parameter int unsigned NUM_REGS = ARCH_REGS
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RegWrite,
  input  reg_addr_t         WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  reg_addr_t         ReadRegister1,
  input  reg_addr_t         ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              IssueValid,
  input  reg_addr_t         IssueRegister,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Overflow
);

  localparam reg_addr_t LAST_REG = reg_addr_t'(NUM_REGS - 1);

  logic [DATA_W-1:0]    regs   [ARCH_REGS];
  pend_cnt_t            counts [ARCH_REGS];
  logic [ARCH_REGS-1:0] sat;
  logic                 overflow_q;
  logic                 wr_en;
  logic                 issue_en;

  assign wr_en    = RegWrite && (WriteRegister != '0);
  assign issue_en = IssueValid && (IssueRegister != '0);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (WriteRegister <= LAST_REG)) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  for (genvar g = 0; g < ARCH_REGS; g++) begin : g_pend
    if (g == 0 || g >= NUM_REGS) begin : g_none
      assign counts[g] = '0;
      assign sat[g]    = 1'b0;
    end else begin : g_cnt
      logic inc;
      logic dec;
      assign inc = issue_en && (IssueRegister == reg_addr_t'(g));
      assign dec = wr_en && (WriteRegister == reg_addr_t'(g));
      pend_counter u_pend (
        .clk   (Clk),
        .rst   (Rst),
        .inc   (inc),
        .dec   (dec),
        .count (counts[g]),
        .sat   (sat[g])
      );
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst)     overflow_q <= 1'b0;
    else if (|sat) overflow_q <= 1'b1;
  end

  assign Overflow = overflow_q;

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (ReadRegister1 != '0 && ReadRegister1 <= LAST_REG)
      ReadData1 = (wr_en && WriteRegister == ReadRegister1) ? WriteData : regs[ReadRegister1];
    if (ReadRegister2 != '0 && ReadRegister2 <= LAST_REG)
      ReadData2 = (wr_en && WriteRegister == ReadRegister2) ? WriteData : regs[ReadRegister2];
  end

  // A last outstanding write that is retiring right now is covered by the bypass.
  always_comb begin
    Busy1 = (ReadRegister1 != '0) && (counts[ReadRegister1] != '0) &&
            !((counts[ReadRegister1] == pend_cnt_t'(1)) && wr_en &&
              (WriteRegister == ReadRegister1));
    Busy2 = (ReadRegister2 != '0) && (counts[ReadRegister2] != '0) &&
            !((counts[ReadRegister2] == pend_cnt_t'(1)) && wr_en &&
              (WriteRegister == ReadRegister2));
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed and randomized checks of reg_file_wb against a behavioural model
// of register contents, pending-write counts and the overflow flag.
module tb_reg_file_wb;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        IssueValid;
  logic [4:0]  IssueRegister;
  logic        Busy1;
  logic        Busy2;
  logic        Overflow;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] m_mem [32];
  int          m_cnt [32];
  logic        m_ovf;

  reg_file_wb #(.DATA_W(32), .NUM_REGS(32)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .IssueValid    (IssueValid),
    .IssueRegister (IssueRegister),
    .Busy1         (Busy1),
    .Busy2         (Busy2),
    .Overflow      (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (RegWrite && WriteRegister != 5'd0 && WriteRegister == ra) return WriteData;
    return m_mem[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
    if (ra == 5'd0 || m_cnt[ra] == 0) return 1'b0;
    if (m_cnt[ra] == 1 && RegWrite && WriteRegister == ra) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_model();
    chk("rd1", ReadData1, exp_rd(ReadRegister1));
    chk("rd2", ReadData2, exp_rd(ReadRegister2));
    chk("busy1", {31'b0, Busy1}, {31'b0, exp_busy(ReadRegister1)});
    chk("busy2", {31'b0, Busy2}, {31'b0, exp_busy(ReadRegister2)});
    chk("ovf", {31'b0, Overflow}, {31'b0, m_ovf});
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic iv, input logic [4:0] ia);
    @(negedge Clk);
    Rst = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = r1; ReadRegister2 = r2; IssueValid = iv; IssueRegister = ia;
    #1;
  endtask

  task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                     input logic iv, input logic [4:0] ia);
    drive(rst, we, wa, wd, r1, r2, iv, ia);
    check_model();
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic tick();
    int net [32];
    int n;
    if (!Rst) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r] = 32'h0;
        m_cnt[r] = 0;
      end
      m_ovf = 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) net[r] = 0;
      if (RegWrite && WriteRegister != 5'd0) begin
        m_mem[WriteRegister] = WriteData;
        net[WriteRegister] -= 1;
      end
      if (IssueValid && IssueRegister != 5'd0) net[IssueRegister] += 1;
      for (int r = 1; r < 32; r++) begin
        n = m_cnt[r] + net[r];
        if (n > 3) begin
          n = 3;
          m_ovf = 1'b1;
        end
        if (n < 0) n = 0;
        m_cnt[r] = n;
      end
    end
    @(posedge Clk);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = 32'h0;
      m_cnt[r] = 0;
    end
    m_ovf = 1'b0;

    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0, 5'd0);
    chk("reset_rd1", ReadData1, 32'h0);
    chk("reset_ovf", {31'b0, Overflow}, 32'h0);
    tick();

    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("r5_next_cycle", ReadData1, 32'hDEADBEEF); tick();

    cyc(1'b1, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("r0_same_cycle", ReadData1, 32'h0); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("r0_next_cycle", ReadData1, 32'h0); tick();

    cyc(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7, 1'b0, 5'd0);
    chk("r7_bypass", ReadData2, 32'hA5A5A5A5); tick();

    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3); tick();
    cyc(1'b1, 1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    chk("r3_busy", {31'b0, Busy1}, 32'h1); tick();
    cyc(1'b1, 1'b1, 5'd3, 32'h22, 5'd3, 5'd0, 1'b0, 5'd0);
    chk("r3_busy_on_wb", {31'b0, Busy1}, 32'h0); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    chk("r3_drained", {31'b0, Busy1}, 32'h0); tick();

    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9); tick();
    end
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    chk("r9_no_ovf_yet", {31'b0, Overflow}, 32'h0); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    chk("r9_ovf_set", {31'b0, Overflow}, 32'h1); tick();
    cyc(1'b1, 1'b1, 5'd9, 32'h9, 5'd9, 5'd0, 1'b0, 5'd0); tick();
    cyc(1'b1, 1'b1, 5'd9, 32'h9, 5'd9, 5'd0, 1'b0, 5'd0); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    chk("r9_held_at_3", {31'b0, Busy1}, 32'h1); tick();
    cyc(1'b1, 1'b1, 5'd9, 32'h9, 5'd9, 5'd0, 1'b0, 5'd0);
    chk("r9_last_wb", {31'b0, Busy1}, 32'h0); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
    chk("r9_ovf_sticky", {31'b0, Overflow}, 32'h1); tick();
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("ovf_cleared", {31'b0, Overflow}, 32'h0);
    chk("r5_cleared", ReadData1, 32'h0); tick();

    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4); tick();
    cyc(1'b1, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0, 1'b1, 5'd4); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
    chk("r4_still_busy", {31'b0, Busy1}, 32'h1); tick();
    cyc(1'b1, 1'b1, 5'd4, 32'h45, 5'd0, 5'd0, 1'b0, 5'd0); tick();

    cyc(1'b0, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0, 1'b1, 5'd6); tick();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd6, 5'd0, 1'b0, 5'd0);
    chk("rst_prio_data", ReadData1, 32'h0);
    chk("rst_prio_busy", {31'b0, Busy1}, 32'h0); tick();

    for (int k = 0; k < 400; k++) begin
      logic [4:0] wa;
      logic [4:0] r1;
      wa = 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      cyc(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1,
          1'($urandom_range(0, 1)), wa, 32'($urandom), r1,
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
